// File: rtl/mult_seq_pkg.sv
// Shared types and defaults for the multiplier operand sequencer.
// States, operand/product widths and cycle budgets.
package mult_seq_pkg;

  localparam int WIDTH          = 16;
  localparam int PROD_W         = 32;
  localparam int DRAIN_CYCLES   = 72;
  localparam int TIMEOUT_CYCLES = 48;

  typedef enum logic [2:0] {
    S_DRAIN,
    S_IDLE,
    S_START,
    S_RUN,
    S_HOLD
  } state_e;

endpackage

// File: rtl/mult_seq_cycle_cnt.sv
// Loadable up-counter with terminal-count compare.
// Saturates at TERM-1; clr reloads zero.
module mult_seq_cycle_cnt #(
  parameter int TERM = 72
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam int W = $clog2(TERM + 1);
  localparam logic [W-1:0] LAST = W'(TERM - 1);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  assign tc = (cnt_q == LAST);

  // Count while enabled, hold at terminal, reload on clear.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && !tc) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mult_operand_sequencer.sv
// Issue/collect stage for the 16x16 sequential multiplier core.
// Optional RUN watchdog: define MULT_SEQ_TIMEOUT_EN.
module mult_operand_sequencer
  import mult_seq_pkg::*;
#(
  parameter int WIDTH = mult_seq_pkg::WIDTH,
`ifdef MULT_SEQ_TIMEOUT_EN
  parameter int TIMEOUT_CYCLES = mult_seq_pkg::TIMEOUT_CYCLES,
`endif
  parameter int DRAIN_CYCLES = mult_seq_pkg::DRAIN_CYCLES
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_mplier,
  input  logic [WIDTH-1:0]   in_mcand,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out_product,
  output logic               mul_st,
  output logic [WIDTH-1:0]   mul_mplier,
  output logic [WIDTH-1:0]   mul_mcand,
  input  logic               mul_done,
  input  logic [2*WIDTH-1:0] mul_product,
  output logic               err
);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic               out_valid_q, out_valid_d;
  logic [2*WIDTH-1:0] out_product_q, out_product_d;
  logic               accept;
  logic               drain_tc;
  logic               to_tc;

  assign in_ready    = (state_q == S_IDLE) |
                       ((state_q == S_HOLD) & out_ready);
  assign accept      = in_valid & in_ready;
  assign mul_st      = (state_q == S_START);
  assign mul_mplier  = mplier_q;
  assign mul_mcand   = mcand_q;
  assign out_valid   = out_valid_q;
  assign out_product = out_product_q;

  mult_seq_cycle_cnt #(
    .TERM (DRAIN_CYCLES)
  ) u_drain_cnt (
    .clk (clk),
    .rst (rst),
    .clr (state_q != S_DRAIN),
    .en  (state_q == S_DRAIN),
    .tc  (drain_tc)
  );

`ifdef MULT_SEQ_TIMEOUT_EN
  logic err_q, err_d;

  mult_seq_cycle_cnt #(
    .TERM (TIMEOUT_CYCLES)
  ) u_timeout_cnt (
    .clk (clk),
    .rst (rst),
    .clr (state_q != S_RUN),
    .en  (state_q == S_RUN),
    .tc  (to_tc)
  );

  assign err = err_q;

  // Sticky timeout flag, cleared only by reset.
  always_comb begin
    err_d = err_q;
    if (state_q == S_RUN && !mul_done && to_tc) begin
      err_d = 1'b1;
    end
  end

  // Error flag register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end
`else
  assign to_tc = 1'b0;
  assign err   = 1'b0;
`endif

  // Next-state, operand latch and result capture.
  always_comb begin
    state_d       = state_q;
    mplier_d      = mplier_q;
    mcand_d       = mcand_q;
    out_valid_d   = out_valid_q;
    out_product_d = out_product_q;
    if (accept) begin
      mplier_d = in_mplier;
      mcand_d  = in_mcand;
    end
    case (state_q)
      S_DRAIN: begin
        if (drain_tc) state_d = S_IDLE;
      end
      S_IDLE: begin
        if (in_valid) state_d = S_START;
      end
      S_START: begin
        state_d = S_RUN;
      end
      S_RUN: begin
        if (mul_done) begin
          out_product_d = mul_product;
          out_valid_d   = 1'b1;
          state_d       = S_HOLD;
        end else if (to_tc) begin
          state_d = S_DRAIN;
        end
      end
      S_HOLD: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = in_valid ? S_START : S_IDLE;
        end
      end
      default: begin
        state_d = S_DRAIN;
      end
    endcase
  end

  // Sequencer registers; reset drops any in-flight result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_DRAIN;
      mplier_q      <= '0;
      mcand_q       <= '0;
      out_valid_q   <= 1'b0;
      out_product_q <= '0;
    end else begin
      state_q       <= state_d;
      mplier_q      <= mplier_d;
      mcand_q       <= mcand_d;
      out_valid_q   <= out_valid_d;
      out_product_q <= out_product_d;
    end
  end

endmodule

// File: tb/tb_mult_operand_sequencer.sv
// Scoreboard bench for mult_operand_sequencer with a behavioural core.
// Timeout expectations follow MULT_SEQ_TIMEOUT_EN.
module tb_mult_operand_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_mplier;
  logic [15:0] in_mcand;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_product;
  logic        mul_st;
  logic [15:0] mul_mplier;
  logic [15:0] mul_mcand;
  logic        mul_done;
  logic [31:0] mul_product;
  logic        err;

  int chk_cnt  = 0;
  int pass_cnt = 0;
  logic [31:0] exp_q[$];

  int          core_lat  = 20;
  bit          core_stub = 1'b0;
  int          core_cnt  = 0;
  logic [15:0] pa, pb;

  always #5 clk = ~clk;

  mult_operand_sequencer dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_mplier   (in_mplier),
    .in_mcand    (in_mcand),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_product (out_product),
    .mul_st      (mul_st),
    .mul_mplier  (mul_mplier),
    .mul_mcand   (mul_mcand),
    .mul_done    (mul_done),
    .mul_product (mul_product),
    .err         (err)
  );

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Behavioural core: done pulse core_lat cycles after start.
  initial begin
    mul_done    = 1'b0;
    mul_product = '0;
    forever begin
      @(negedge clk);
      mul_done = 1'b0;
      if (core_cnt > 0) begin
        core_cnt--;
        if (core_cnt == 0) begin
          mul_done    = 1'b1;
          mul_product = 32'(pa) * 32'(pb);
        end
      end
      if (mul_st && !core_stub) begin
        pa       = mul_mplier;
        pb       = mul_mcand;
        core_cnt = core_lat;
      end
    end
  end

  // Monitor: compare every accepted product with the scoreboard.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) check("sb_unexpected", 32'd1, 32'd0);
      else check("product", out_product, exp_q.pop_front());
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [15:0] a, input logic [15:0] b,
                      input bit push, input logic [31:0] e);
    int n;
    in_valid  = 1'b1;
    in_mplier = a;
    in_mcand  = b;
    n = 0;
    #1;
    while (!in_ready && n < 300) begin
      cyc();
      n++;
    end
    if (!in_ready) check("accept_timeout", 32'd0, 32'd1);
    else if (push) exp_q.push_back(e);
    cyc();
    in_valid = 1'b0;
  endtask

  task automatic wait_out(output int n);
    n = 0;
    while (!out_valid && n < 200) begin
      cyc();
      n++;
    end
    if (!out_valid) check("out_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    int n;
    bit bad;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_mplier = '0;
    in_mcand  = '0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_product", out_product, 32'd0);
    check("rst_mul_st", 32'(mul_st), 32'd0);
    check("rst_mplier", 32'(mul_mplier), 32'd0);
    check("rst_mcand", 32'(mul_mcand), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd0);

    // Drain length with in_valid held high.
    rst       = 1'b0;
    in_valid  = 1'b1;
    in_mplier = 16'd3;
    in_mcand  = 16'd5;
    #1;
    n = 0;
    while (!in_ready && n < 300) begin
      cyc();
      n++;
    end
    check("drain_len", 32'(n), 32'd72);
    exp_q.push_back(32'h0000000F);
    cyc();
    in_valid = 1'b0;
    check("st_pulse_hi", 32'(mul_st), 32'd1);
    cyc();
    check("st_pulse_lo", 32'(mul_st), 32'd0);

    // Basic product, operands stable through RUN.
    n   = 1;
    bad = 1'b0;
    while (!out_valid && n < 100) begin
      if (mul_mcand !== 16'd5 || mul_mplier !== 16'd3) bad = 1'b1;
      if (mul_st) bad = 1'b1;
      cyc();
      n++;
    end
    check("latency_ok", 32'(out_valid && n <= 42), 32'd1);
    check("operands_stable", 32'(bad), 32'd0);
    cyc();

    send(16'hFFFF, 16'hFFFF, 1'b1, 32'hFFFE0001);
    wait_out(n);
    cyc();
    send(16'h0000, 16'h1234, 1'b1, 32'h00000000);
    wait_out(n);
    cyc();

    // Backpressure then same-cycle accept.
    out_ready = 1'b0;
    send(16'd7, 16'd9, 1'b1, 32'd63);
    wait_out(n);
    bad = 1'b0;
    repeat (10) begin
      if (!out_valid || out_product !== 32'd63 || in_ready || mul_st)
        bad = 1'b1;
      cyc();
    end
    check("bp_stable", 32'(bad), 32'd0);
    in_valid  = 1'b1;
    in_mplier = 16'd2;
    in_mcand  = 16'd8;
    out_ready = 1'b1;
    #1;
    check("bp_in_ready", 32'(in_ready), 32'd1);
    exp_q.push_back(32'd16);
    cyc();
    in_valid = 1'b0;
    check("bp_st_next", 32'(mul_st), 32'd1);
    check("bp_operand", 32'(mul_mplier), 32'd2);
    wait_out(n);
    cyc();

    // Reset in the middle of RUN.
    send(16'd4, 16'd4, 1'b0, 32'd0);
    repeat (10) cyc();
    rst = 1'b1;
    #1;
    check("midrun_out_valid", 32'(out_valid), 32'd0);
    check("midrun_in_ready", 32'(in_ready), 32'd0);
    check("midrun_mplier", 32'(mul_mplier), 32'd0);
    cyc();
    cyc();
    rst = 1'b0;
    bad = 1'b0;
    repeat (40) begin
      if (out_valid || mul_st) bad = 1'b1;
      cyc();
    end
    check("late_done_ignored", 32'(bad), 32'd0);

    // Core that never finishes.
    core_stub = 1'b1;
    send(16'd1, 16'd1, 1'b0, 32'd0);
    cyc();
    n   = 0;
    bad = 1'b0;
    while (!err && n < 100) begin
      if (out_valid) bad = 1'b1;
      cyc();
      n++;
    end
`ifdef MULT_SEQ_TIMEOUT_EN
    check("timeout_cycles", 32'(n), 32'd48);
    check("timeout_out_valid", 32'(bad), 32'd0);
    check("timeout_drain", 32'(in_ready), 32'd0);
    cyc();
    check("timeout_err_sticky", 32'(err), 32'd1);
`else
    check("no_timeout_err", 32'(err), 32'd0);
    check("no_timeout_wait", 32'(n), 32'd100);
    check("no_timeout_out_valid", 32'(bad), 32'd0);
    check("no_timeout_in_ready", 32'(in_ready), 32'd0);
`endif

    check("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/mult_operand_sequencer.md
Name: mult_operand_sequencer

Overview:
Issue/collect stage in front of the 16x16 sequential shift-add multiplier core.
- Accepts operand pairs on a valid/ready stream.
- Holds the operands stable on the core inputs for the whole operation and pulses the core start for exactly one cycle.
- Waits for the core done, registers the 32-bit product and presents it on a valid/ready output stream.
- One operation in flight. The core has no reset, so this block also owns recovery after reset and aborts.

Parameters:
WIDTH, 16, operand width; must be 16 to match the core.
DRAIN_CYCLES, 72, cycles start is held low after reset or abort so the core returns to idle (core worst case is 64).
TIMEOUT_CYCLES, 48, maximum RUN cycles before abort; used only with the optional feature.

Ports:
clk  in  1  single clock, rising edge
rst  in  1  asynchronous, active-high reset
in_valid  in  1  operand pair valid
in_ready  out  1  sequencer can accept a pair
in_mplier  in  16  multiplier operand
in_mcand  in  16  multiplicand operand
out_valid  out  1  product valid
out_ready  in  1  consumer accepts product
out_product  out  32  registered product
mul_st  out  1  core start, one-cycle pulse
mul_mplier  out  16  registered operand to core
mul_mcand  out  16  registered operand to core, held through RUN
mul_done  in  1  core done pulse
mul_product  in  32  core product, valid while mul_done=1
err  out  1  sticky timeout flag; constant 0 when the feature is off

Behaviour:
Reset (async, asserted):
- state=DRAIN, drain counter=0.
- out_valid=0, out_product=0, mul_st=0, mul_mplier=0, mul_mcand=0, err=0.

FSM states:
- DRAIN: in_ready=0, mul_st=0, mul_done ignored. Counter increments; after DRAIN_CYCLES cycles, go to IDLE.
- IDLE: in_ready=1. On in_valid, latch in_mplier/in_mcand into mul_mplier/mul_mcand, go to START.
- START: mul_st=1 for this single cycle only, then go to RUN. mul_st is never high on two consecutive cycles.
- RUN: mul_st=0, operands held.
  - mul_done=1: capture mul_product into out_product, set out_valid=1, go to HOLD.
  - Expected core latency is 17..40 cycles after START; the block must not depend on the exact value.
- HOLD: out_valid=1; out_product stable until the handshake completes.
  - out_ready=1 and in_valid=0: clear out_valid, go to IDLE.
  - out_ready=1 and in_valid=1: clear out_valid, latch the new operands, go to START.

Handshake rules:
- in_ready = (state==IDLE) | (state==HOLD & out_ready). This is the only combinational path, out_ready to in_ready; it is allowed.
- Back-to-back throughput: one product per (core latency + 2) cycles.

Boundary cases:
- mul_done outside RUN is ignored (no capture, no error).
- mul_done in the same cycle as the START->RUN transition is ignored.
- Reset mid-RUN: the in-flight result is discarded and the block goes to DRAIN.
- Operand registers change only on an accepted input handshake.
- Product is unsigned: 0xFFFF*0xFFFF=0xFFFE0001.

Optional Feature:
MULT_SEQ_TIMEOUT_EN
- Defined: a RUN cycle counter clears on entering RUN. If it reaches TIMEOUT_CYCLES with no mul_done, set err=1 (sticky, cleared only by rst), drop the transaction (out_valid stays 0) and go to DRAIN.
- Undefined: RUN waits indefinitely, no counter is instantiated, and err is tied to 0.

Decomposition:
- Package mult_seq_pkg: state enum (DRAIN, IDLE, START, RUN, HOLD), WIDTH=16, PROD_W=32, DRAIN_CYCLES and TIMEOUT_CYCLES defaults.
- One sub-module: mult_seq_cycle_cnt, a loadable up-counter with terminal-count compare. One instance for drain; a second for timeout under the macro.

Test Plan:
- Reset then idle: rst released, in_valid=1 held -> in_ready=0 for 72 cycles; first accept on cycle 72; mul_st high exactly 1 cycle.
- Basic: mplier=3, mcand=5 -> out_valid rises within 42 cycles of accept, out_product=0x0000000F; mul_mcand stable =5 throughout RUN.
- Max operands: 0xFFFF x 0xFFFF -> out_product=0xFFFE0001. Also 0 x 0x1234 -> 0x00000000.
- Backpressure: result pending with out_ready=0 for 10 cycles -> out_valid and out_product stable, in_ready=0, no mul_st. Then out_ready=1 with in_valid=1 -> same-cycle accept, mul_st next cycle.
- Reset mid-RUN: assert rst 10 cycles after START -> out_valid=0 immediately; a late mul_done during DRAIN produces no output.
- Timeout (macro defined, stubbed core never asserts done): err=1 exactly 48 cycles after entering RUN, out_valid stays 0, DRAIN follows. Without the macro, err=0 and the block stays in RUN.
